// File: rtl/dac_sample_axil_slave.sv
// AXI4-Lite register slave that feeds a 16-bit sample FIFO toward a DAC.
// The map holds CTRL, SAMPLE (push port), STATUS and SCRATCH.
module dac_sample_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [15:0]                       dac_data,
   output logic                              dac_valid,
   input  logic                              dac_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_SAMPLE  = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   logic             awready_q;
   logic             bvalid_q;
   logic [1:0]       bresp_q;
   logic             arready_q;
   logic             rvalid_q;
   logic [1:0]       rresp_q;
   logic [31:0]      rdata_q;
   logic             enable_q, enable_d;
   logic [31:0]      scratch_q, scratch_d;
   logic [15:0]      last_sample_q, last_sample_d;
   logic             overflow_q, overflow_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [15:0]      dac_data_q, dac_data_d;
   logic             dac_valid_q, dac_valid_d;
   logic [15:0]      mem_q [FIFO_DEPTH];

   logic             wr_fire_s, rd_fire_s;
   logic [1:0]       wr_sel_s, rd_sel_s;
   logic             full_s, pop_s, sample_wr_s, clear_s, push_s, drop_s;
   logic [31:0]      level_ext_s, status_s, rdata_mux_s;
   logic [15:0]      head_s;
   logic             unused_s;

   // A write lands on the edge where the registered ready meets both valids.
   assign wr_fire_s   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire_s   = arready_q & S_AXI_ARVALID;
   assign wr_sel_s    = S_AXI_AWADDR[3:2];
   assign rd_sel_s    = S_AXI_ARADDR[3:2];
   assign full_s      = (level_q == DEPTH_L);
   assign pop_s       = dac_valid_q & dac_ready;
   assign sample_wr_s = wr_fire_s & (wr_sel_s == REG_SAMPLE) & (S_AXI_WSTRB[1:0] == 2'b11);
   assign clear_s     = wr_fire_s & (wr_sel_s == REG_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
   assign push_s      = sample_wr_s & ~clear_s & (~full_s | pop_s);
   assign drop_s      = sample_wr_s & ~clear_s & full_s & ~pop_s;
   assign level_ext_s = 32'(level_q);
   assign status_s    = {21'h0, (level_q == LVL_ZERO), full_s, overflow_q, level_ext_s[7:0]};
   assign unused_s    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, level_ext_s[31:8]};

   // FIFO pointer/level next state; clear overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear_s) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         level_d  = LVL_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Register-file next state for CTRL, STATUS overflow, SCRATCH and SAMPLE.
   always_comb begin
      enable_d      = enable_q;
      overflow_d    = overflow_q;
      scratch_d     = scratch_q;
      last_sample_d = last_sample_q;
      if (wr_fire_s && (wr_sel_s == REG_CTRL) && S_AXI_WSTRB[0]) begin
         enable_d = S_AXI_WDATA[0];
      end else begin
         enable_d = enable_q;
      end
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (wr_fire_s && (wr_sel_s == REG_STATUS) && S_AXI_WSTRB[1] && S_AXI_WDATA[8]) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      for (int b = 0; b < 4; b++) begin
         if (wr_fire_s && (wr_sel_s == REG_SCRATCH) && S_AXI_WSTRB[b]) begin
            scratch_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
         end else begin
            scratch_d[8*b +: 8] = scratch_q[8*b +: 8];
         end
      end
      if (push_s) begin
         last_sample_d = S_AXI_WDATA[15:0];
      end else begin
         last_sample_d = last_sample_q;
      end
   end

   // The slot being written this edge may become the new head; forward it.
   always_comb begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_s = S_AXI_WDATA[15:0];
      end else begin
         head_s = mem_q[rd_ptr_d];
      end
      dac_valid_d = enable_d & (level_d != LVL_ZERO);
      if (dac_valid_d) begin
         dac_data_d = head_s;
      end else begin
         dac_data_d = 16'h0000;
      end
   end

   // Read data mux, sampled into RDATA at read accept.
   always_comb begin
      case (rd_sel_s)
         REG_CTRL:    rdata_mux_s = {31'h0, enable_q};
         REG_SAMPLE:  rdata_mux_s = {16'h0000, last_sample_q};
         REG_STATUS:  rdata_mux_s = status_s;
         REG_SCRATCH: rdata_mux_s = scratch_q;
         default:     rdata_mux_s = 32'h0000_0000;
      endcase
   end

   // Sample storage; contents need no reset since level gates visibility.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESETN && push_s) begin
         mem_q[wr_ptr_q] <= S_AXI_WDATA[15:0];
      end
   end

   // Handshake, register and FIFO state with synchronous active-low reset.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         awready_q     <= 1'b0;
         bvalid_q      <= 1'b0;
         bresp_q       <= RESP_OKAY;
         arready_q     <= 1'b0;
         rvalid_q      <= 1'b0;
         rresp_q       <= RESP_OKAY;
         rdata_q       <= 32'h0000_0000;
         enable_q      <= 1'b0;
         scratch_q     <= 32'h0000_0000;
         last_sample_q <= 16'h0000;
         overflow_q    <= 1'b0;
         wr_ptr_q      <= PTR_ZERO;
         rd_ptr_q      <= PTR_ZERO;
         level_q       <= LVL_ZERO;
         dac_data_q    <= 16'h0000;
         dac_valid_q   <= 1'b0;
      end else begin
         awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
         if (wr_fire_s) begin
            bvalid_q <= 1'b1;
            bresp_q  <= drop_s ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
         arready_q <= S_AXI_ARVALID & ~arready_q & ~rvalid_q;
         if (rd_fire_s) begin
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= rdata_mux_s;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
         enable_q      <= enable_d;
         scratch_q     <= scratch_d;
         last_sample_q <= last_sample_d;
         overflow_q    <= overflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         dac_data_q    <= dac_data_d;
         dac_valid_q   <= dac_valid_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign dac_data      = dac_data_q;
   assign dac_valid     = dac_valid_q;

endmodule

// File: tb/tb_dac_sample_axil_slave.sv
// Scoreboard bench: tasks queue expected B/R/DAC responses, a negedge monitor
// pops and compares them whenever the DUT completes a handshake.
module tb_dac_sample_axil_slave;

   localparam logic [3:0] A_CTRL    = 4'h0;
   localparam logic [3:0] A_SAMPLE  = 4'h4;
   localparam logic [3:0] A_STATUS  = 4'h8;
   localparam logic [3:0] A_SCRATCH = 4'hC;
   localparam logic [1:0] OKAY      = 2'b00;
   localparam logic [1:0] SLVERR    = 2'b10;

   logic        clk = 1'b0;
   logic        S_AXI_ARESETN;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [15:0] dac_data;
   logic        dac_valid;
   logic        dac_ready;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   logic [1:0]  exp_b_q[$];
   logic [31:0] exp_r_q[$];
   logic [15:0] exp_dac_q[$];
   int          pop_cyc_q[$];

   dac_sample_axil_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4),
      .FIFO_DEPTH(16)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(S_AXI_ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR),
      .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA),
      .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR),
      .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA),
      .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .dac_data(dac_data),
      .dac_valid(dac_valid),
      .dac_ready(dac_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expired(input string name);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: no handshake within 50 cycles (t=%0t)", name, $time);
   endtask

   // Monitor: compare every completed B, R and DAC handshake to the queues.
   always @(negedge clk) begin : monitor
      logic [1:0]  eb;
      logic [31:0] er;
      logic [15:0] ed;
      if (S_AXI_ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
         if (exp_b_q.size() == 0) expired("b_unexpected");
         else begin
            eb = exp_b_q.pop_front();
            chk("bresp", 64'(S_AXI_BRESP), 64'(eb));
         end
      end
      if (S_AXI_ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
         if (exp_r_q.size() == 0) expired("r_unexpected");
         else begin
            er = exp_r_q.pop_front();
            chk("rresp_rdata", 64'({S_AXI_RRESP, S_AXI_RDATA}), 64'({OKAY, er}));
         end
      end
      if (S_AXI_ARESETN && dac_valid && dac_ready) begin
         pop_cyc_q.push_back(cyc);
         if (exp_dac_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL dac_unexpected: popped 0x%0h, expected no pop", dac_data);
         end else begin
            ed = exp_dac_q.pop_front();
            chk("dac_data", 64'(dac_data), 64'(ed));
         end
      end
   end

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input bit track);
      int n;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50);
      if (!(S_AXI_AWREADY && S_AXI_WREADY)) expired("aw_accept");
      else if (track) exp_b_q.push_back(exp_resp);
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (track) begin
         n = 0;
         while (!(S_AXI_BVALID && S_AXI_BREADY) && n < 50) begin @(negedge clk); n++; end
         if (!(S_AXI_BVALID && S_AXI_BREADY)) expired("b_handshake");
         @(posedge clk); #1;
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data, input bit track);
      int n;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 50);
      if (!S_AXI_ARREADY) expired("ar_accept");
      else if (track) exp_r_q.push_back(exp_data);
      @(posedge clk); #1;
      S_AXI_ARVALID = 1'b0;
      if (track) begin
         n = 0;
         while (!(S_AXI_RVALID && S_AXI_RREADY) && n < 50) begin @(negedge clk); n++; end
         if (!(S_AXI_RVALID && S_AXI_RREADY)) expired("r_handshake");
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWADDR  = 4'h0;
      S_AXI_AWPROT  = 3'b000;
      S_AXI_WDATA   = 32'h0;
      S_AXI_WSTRB   = 4'h0;
      S_AXI_ARADDR  = 4'h0;
      S_AXI_ARPROT  = 3'b000;
      S_AXI_BREADY  = 1'b1;
      S_AXI_RREADY  = 1'b1;
      dac_ready     = 1'b0;
      // Valids held high through reset: readies must stay low.
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARVALID = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_axi_ctl", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                              S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP}), 64'(0));
      chk("rst_rdata", 64'(S_AXI_RDATA), 64'(0));
      chk("rst_dac", 64'({dac_valid, dac_data}), 64'(0));
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_ARESETN = 1'b1;
      @(posedge clk); #1;

      axi_read(A_CTRL,    32'h0000_0000, 1'b1);
      axi_read(A_SAMPLE,  32'h0000_0000, 1'b1);
      axi_read(A_STATUS,  32'h0000_0400, 1'b1);
      axi_read(A_SCRATCH, 32'h0000_0000, 1'b1);

      // Scratch full write then single-lane write.
      axi_write(A_SCRATCH, 32'hDEAD_BEEF, 4'hF, OKAY, 1'b1);
      axi_read (A_SCRATCH, 32'hDEAD_BEEF, 1'b1);
      axi_write(A_SCRATCH, 32'h0000_0011, 4'h1, OKAY, 1'b1);
      axi_read (A_SCRATCH, 32'hDEAD_BE11, 1'b1);

      // Partial-strobe sample write is ignored; then fill and overflow.
      axi_write(A_SAMPLE, 32'h0000_0055, 4'h1, OKAY, 1'b1);
      axi_read (A_STATUS, 32'h0000_0400, 1'b1);
      axi_read (A_SAMPLE, 32'h0000_0000, 1'b1);
      for (int i = 1; i <= 16; i++) axi_write(A_SAMPLE, 32'(i), 4'hF, OKAY, 1'b1);
      axi_read (A_STATUS, 32'h0000_0210, 1'b1);
      axi_write(A_SAMPLE, 32'h0000_0011, 4'hF, SLVERR, 1'b1);
      axi_read (A_STATUS, 32'h0000_0310, 1'b1);
      axi_read (A_SAMPLE, 32'h0000_0010, 1'b1);

      // Enable with consumer ready: 16 samples drain on consecutive cycles.
      for (int i = 1; i <= 16; i++) exp_dac_q.push_back(16'(i));
      pop_cyc_q.delete();
      dac_ready = 1'b1;
      axi_write(A_CTRL, 32'h0000_0001, 4'hF, OKAY, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      chk("drain_count", 64'(pop_cyc_q.size()), 64'(16));
      if (pop_cyc_q.size() == 16)
         chk("drain_back_to_back", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'(15));
      chk("drain_dac_valid", 64'(dac_valid), 64'(0));
      axi_read (A_STATUS, 32'h0000_0500, 1'b1);
      axi_write(A_STATUS, 32'h0000_0100, 4'hF, OKAY, 1'b1);
      axi_read (A_STATUS, 32'h0000_0400, 1'b1);

      // Full FIFO, push coinciding with a single pop.
      dac_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         axi_write(A_SAMPLE, 32'h0A00 + 32'(i), 4'hF, OKAY, 1'b1);
         exp_dac_q.push_back(16'h0A00 + 16'(i));
      end
      exp_dac_q.push_back(16'h1234);
      axi_read(A_STATUS, 32'h0000_0210, 1'b1);
      chk("full_dac_head", 64'({dac_valid, dac_data}), 64'({1'b1, 16'h0A01}));
      S_AXI_AWADDR  = A_SAMPLE;
      S_AXI_WDATA   = 32'h0000_1234;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      exp_b_q.push_back(OKAY);
      @(posedge clk); #1;
      chk("full_push_awready", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(2'b11));
      dac_ready = 1'b1;
      @(posedge clk); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      dac_ready     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      axi_read(A_STATUS, 32'h0000_0210, 1'b1);
      dac_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("full_push_drained", 64'(exp_dac_q.size()), 64'(0));
      axi_read(A_STATUS, 32'h0000_0400, 1'b1);

      // Clear with pending samples while enabled.
      dac_ready = 1'b0;
      for (int i = 1; i <= 8; i++) axi_write(A_SAMPLE, 32'h0B00 + 32'(i), 4'hF, OKAY, 1'b1);
      axi_read (A_STATUS, 32'h0000_0008, 1'b1);
      axi_write(A_CTRL, 32'h0000_0003, 4'hF, OKAY, 1'b1);
      chk("clear_dac_valid", 64'(dac_valid), 64'(0));
      axi_read(A_STATUS, 32'h0000_0400, 1'b1);
      axi_read(A_CTRL,   32'h0000_0001, 1'b1);
      dac_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      dac_ready = 1'b0;

      // Stalled responses, then reset in the middle of the stall.
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      axi_write(A_SCRATCH, 32'h1234_5678, 4'hF, OKAY, 1'b0);
      axi_read (A_SCRATCH, 32'h0, 1'b0);
      S_AXI_AWADDR  = A_CTRL;
      S_AXI_WDATA   = 32'h0000_0003;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARADDR  = A_STATUS;
      S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_hold", 64'({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                                 S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}),
             64'({1'b0, 1'b0, 1'b1, 1'b1, OKAY, OKAY, 32'h1234_5678}));
      end
      @(posedge clk); #1;
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_outs", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}), 64'(0));
      chk("midreset_dac", 64'({dac_valid, dac_data}), 64'(0));
      @(posedge clk); #1;
      S_AXI_ARESETN = 1'b1;
      S_AXI_BREADY  = 1'b1;
      S_AXI_RREADY  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("aborted_no_resp", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
      @(posedge clk); #1;
      axi_read(A_SCRATCH, 32'h0000_0000, 1'b1);
      axi_read(A_CTRL,    32'h0000_0000, 1'b1);
      axi_read(A_STATUS,  32'h0000_0400, 1'b1);
      axi_read(A_SAMPLE,  32'h0000_0000, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("b_queue_empty",   64'(exp_b_q.size()),   64'(0));
      chk("r_queue_empty",   64'(exp_r_q.size()),   64'(0));
      chk("dac_queue_empty", 64'(exp_dac_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
